// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-read-port integer register file.
//
// Purpose:
//   Register array for the pipelined RV32I core. It provides NREAD independent
//   combinational read ports and one write port. A per-register busy scoreboard
//   is set at issue (bset) and cleared at writeback (we). A clear engine zeroes
//   one entry per cycle after reset or after a clear_req pulse. Register 0 is
//   hardwired to zero and never reports busy.
//
// Configuration macro:
//   REGFILE_MP_BYPASS_EN -- when defined, a write in the current cycle is
//   forwarded to any read port that addresses the same register.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset (restarts the clear)
//   clear_req    in   one-cycle pulse; starts a clear, honoured only in READY
//   ready        out  array usable (low while clearing)
//   we           in   write enable
//   waddr        in   [AW-1:0] write address
//   wdata        in   [XLEN-1:0] write data
//   raddr        in   [NREAD*AW-1:0] read addresses, port k at [k*AW +: AW]
//   rdata        out  [NREAD*XLEN-1:0] read data, port k at [k*XLEN +: XLEN]
//   rbusy        out  [NREAD-1:0] busy flag of each addressed register
//   bset         in   mark bset_addr busy
//   bset_addr    in   [AW-1:0] register to mark busy
//   dbg_state    out  FSM state (0 = CLEAR, 1 = READY)
//   dbg_idx      out  [AW-1:0] clear engine index
//
// Handshake note: there is no valid/ready pairing here. 'ready' is a level
// that says whether writes, bset and clear_req are honoured this cycle; while
// it is low those inputs are dropped (not stalled) and all read outputs are 0.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  bset,
  input  logic [AW-1:0]         bset_addr,
  output logic                  dbg_state,
  output logic [AW-1:0]         dbg_idx
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_idx;
  logic [NREGS-1:0]  r_busy;
  logic [XLEN-1:0]   r_regs [NREGS];

  logic              w_ready;
  logic              w_wr_en;
  logic              w_bset_en;

  assign w_ready   = (r_state == S_READY);
  assign w_wr_en   = w_ready && we   && (waddr     != '0);
  assign w_bset_en = w_ready && bset && (bset_addr != '0);

  assign ready     = w_ready;
  assign dbg_state = r_state;
  assign dbg_idx   = r_idx;

  // Control FSM and busy scoreboard. Busy lives here because it must be zeroed
  // by the asynchronous reset, unlike the data array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
      r_busy  <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_busy[r_idx] <= 1'b0;
          // idx wraps back to 0 naturally after the last entry.
          r_idx <= r_idx + 1'b1;
          if (r_idx == AW'(NREGS - 1)) begin
            r_state <= S_READY;
          end
        end
        S_READY: begin
          if (w_wr_en) begin
            r_busy[waddr] <= 1'b0;
          end
          // Later assignment wins: a bset to the register being written
          // keeps it busy (a newer producer has issued).
          if (w_bset_en) begin
            r_busy[bset_addr] <= 1'b1;
          end
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Data array: no reset, contents are defined once the clear engine has
  // swept every entry.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Read ports.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;
    logic          w_zero;

    assign w_ra   = raddr[k*AW +: AW];
    assign w_zero = !w_ready || (w_ra == '0);

`ifdef REGFILE_MP_BYPASS_EN
    assign w_hit = w_wr_en && (waddr == w_ra);
`else
    assign w_hit = 1'b0;
`endif

    assign rdata[k*XLEN +: XLEN] = w_zero ? '0 :
                                   w_hit  ? wdata : r_regs[w_ra];
    // On a bypass hit the write clears busy unless a same-cycle bset to the
    // same register re-marks it.
    assign rbusy[k] = w_zero ? 1'b0 :
                      w_hit  ? (w_bset_en && (bset_addr == w_ra)) : r_busy[w_ra];
  end

endmodule
